// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard unit.
//   fwd_sel_e : E-stage forwarding mux select (RF, W, M, long-unit result)
//   REG_X0    : architectural zero register, never tracked or forwarded
//   fwd_pick  : priority encoder turning per-source hit flags into a select
// ---------------------------------------------------------------------------
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_W    = 2'b01,
    FWD_M    = 2'b10,
    FWD_LONG = 2'b11
  } fwd_sel_e;

  localparam int REG_X0 = 0;

  // The long unit's writeback is the youngest value, then M, then W.
  function automatic fwd_sel_e fwd_pick(input logic long_hit,
                                        input logic m_hit,
                                        input logic w_hit);
    if (long_hit)   return FWD_LONG;
    else if (m_hit) return FWD_M;
    else if (w_hit) return FWD_W;
    else            return FWD_RF;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Tracks registers whose value is owed by an outstanding long-latency op.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   set_valid, set_rd      long op dispatched this edge, its destination
//   clr_valid, clr_rd      long unit writes back this cycle, its destination
//   q_a, q_b, q_c          three register addresses to query
//   busy_a, busy_b, busy_c query results, including same-cycle set/clear
//   clr_hit                the writeback retires a genuinely pending register
//   pend_cnt               number of outstanding long ops
//   err_spurious           sticky: writeback for a register that was not pending
// ---------------------------------------------------------------------------
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int MAX_PEND = 4,
  parameter int PC_W     = $clog2(MAX_PEND + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_valid,
  input  logic [RA_W-1:0] set_rd,
  input  logic            clr_valid,
  input  logic [RA_W-1:0] clr_rd,
  input  logic [RA_W-1:0] q_a,
  input  logic [RA_W-1:0] q_b,
  input  logic [RA_W-1:0] q_c,
  output logic            busy_a,
  output logic            busy_b,
  output logic            busy_c,
  output logic            clr_hit,
  output logic [PC_W-1:0] pend_cnt,
  output logic            err_spurious
);

  localparam int NREGS = 1 << RA_W;
  localparam logic [RA_W-1:0] X0 = RA_W'(REG_X0);
  localparam logic [PC_W-1:0] CNT_MAX = PC_W'(MAX_PEND);

  logic [NREGS-1:0] pend;
  logic             set_eff;

  assign set_eff = set_valid && (set_rd != X0);
  assign clr_hit = clr_valid && pend[clr_rd];

  // A register issued this edge is already busy; one retired this cycle is
  // already free, so consumers see the scoreboard with zero lag.
  function automatic logic busy_of(input logic [RA_W-1:0] r,
                                   input logic            pend_bit,
                                   input logic            sv,
                                   input logic [RA_W-1:0] sr,
                                   input logic            cv,
                                   input logic [RA_W-1:0] cr);
    return (r != X0) && (pend_bit || (sv && (sr == r))) && !(cv && (cr == r));
  endfunction

  assign busy_a = busy_of(q_a, pend[q_a], set_valid, set_rd, clr_valid, clr_rd);
  assign busy_b = busy_of(q_b, pend[q_b], set_valid, set_rd, clr_valid, clr_rd);
  assign busy_c = busy_of(q_c, pend[q_c], set_valid, set_rd, clr_valid, clr_rd);

  // Clear is written before set so a same-register set/clear leaves the bit
  // set; the count moves by set minus clear, which nets to zero in that case.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend         <= '0;
      pend_cnt     <= '0;
      err_spurious <= 1'b0;
    end else begin
      if (clr_hit) pend[clr_rd] <= 1'b0;
      if (set_eff) pend[set_rd] <= 1'b1;
      if (set_eff && !clr_hit) begin
        if (pend_cnt != CNT_MAX) pend_cnt <= pend_cnt + 1'b1;
      end else if (!set_eff && clr_hit) begin
        pend_cnt <= pend_cnt - 1'b1;
      end
      if (clr_valid && !pend[clr_rd]) err_spurious <= 1'b1;
    end
  end

  // Issuing into a full scoreboard with nothing retiring is a protocol error
  // upstream; the counter clamps rather than wrapping.
  assert property (@(posedge clk) disable iff (rst)
                   !(set_eff && !clr_hit && (pend_cnt == CNT_MAX)));

endmodule

// File: rtl/hazard_unit_sb.sv
// ---------------------------------------------------------------------------
// hazard_unit_sb
// Hazard unit for the 5-stage core: forwarding selects, load-use, branch
// compare and scoreboard stalls, and a saturating stall-cycle counter.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   Rs1D, Rs2D, RdD, BranchD, LongD   decode-stage instruction
//   Rs1E, Rs2E, RdE, RegWriteE, LoadE, LongIssueE   execute-stage instruction
//   RdM, RegWriteM, LoadM         memory-stage instruction
//   RdW, RegWriteW                writeback-stage instruction
//   LongDoneValid, LongDoneRd     long-unit writeback
//   ForwardAE, ForwardBE          E operand selects (fwd_sel_e encoding)
//   ForwardAD, ForwardBD          forward ALUResultM into D comparator
//   StallF, StallD, FlushE, Stall all equal to the OR of the stall causes
//   PendCnt                       outstanding long ops
//   StallCycles                   saturating count of stalled cycles
//   ErrSpurious                   sticky spurious-writeback flag
// ---------------------------------------------------------------------------
module hazard_unit_sb
  import hazard_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int MAX_PEND = 4,
  parameter int CNT_W    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [RA_W-1:0]                Rs1D,
  input  logic [RA_W-1:0]                Rs2D,
  input  logic [RA_W-1:0]                RdD,
  input  logic                           BranchD,
  input  logic                           LongD,
  input  logic [RA_W-1:0]                Rs1E,
  input  logic [RA_W-1:0]                Rs2E,
  input  logic [RA_W-1:0]                RdE,
  input  logic                           RegWriteE,
  input  logic                           LoadE,
  input  logic                           LoadM,
  input  logic                           LongIssueE,
  input  logic [RA_W-1:0]                RdM,
  input  logic [RA_W-1:0]                RdW,
  input  logic                           RegWriteM,
  input  logic                           RegWriteW,
  input  logic                           LongDoneValid,
  input  logic [RA_W-1:0]                LongDoneRd,
  output logic [1:0]                     ForwardAE,
  output logic [1:0]                     ForwardBE,
  output logic                           ForwardAD,
  output logic                           ForwardBD,
  output logic                           StallF,
  output logic                           StallD,
  output logic                           FlushE,
  output logic                           Stall,
  output logic [$clog2(MAX_PEND+1)-1:0]  PendCnt,
  output logic [CNT_W-1:0]               StallCycles,
  output logic                           ErrSpurious
);

  localparam int PC_W = $clog2(MAX_PEND + 1);
  localparam logic [RA_W-1:0] X0 = RA_W'(REG_X0);

  logic     busy_rs1, busy_rs2, busy_rd;
  logic     clr_hit;
  logic     lw_stall, br_stall, sb_stall, full_stall;
  logic     rs1d_hit_e, rs1d_hit_m;
  fwd_sel_e sel_a, sel_b;
  logic [PC_W:0] occupancy, limit;

  reg_scoreboard #(
    .RA_W     (RA_W),
    .MAX_PEND (MAX_PEND),
    .PC_W     (PC_W)
  ) u_sb (
    .clk          (clk),
    .rst          (rst),
    .set_valid    (LongIssueE),
    .set_rd       (RdE),
    .clr_valid    (LongDoneValid),
    .clr_rd       (LongDoneRd),
    .q_a          (Rs1D),
    .q_b          (Rs2D),
    .q_c          (RdD),
    .busy_a       (busy_rs1),
    .busy_b       (busy_rs2),
    .busy_c       (busy_rd),
    .clr_hit      (clr_hit),
    .pend_cnt     (PendCnt),
    .err_spurious (ErrSpurious)
  );

  // E-stage operand forwarding; x0 always reads the register file.
  always_comb begin
    sel_a = fwd_pick((Rs1E != X0) && LongDoneValid && (LongDoneRd == Rs1E),
                     (Rs1E != X0) && RegWriteM && (RdM == Rs1E),
                     (Rs1E != X0) && RegWriteW && (RdW == Rs1E));
    sel_b = fwd_pick((Rs2E != X0) && LongDoneValid && (LongDoneRd == Rs2E),
                     (Rs2E != X0) && RegWriteM && (RdM == Rs2E),
                     (Rs2E != X0) && RegWriteW && (RdW == Rs2E));
  end

  assign ForwardAE = sel_a;
  assign ForwardBE = sel_b;

  // A load in M has no ALU result yet, so it cannot feed the comparator.
  assign ForwardAD = (Rs1D != X0) && RegWriteM && (RdM == Rs1D) && !LoadM;
  assign ForwardBD = (Rs2D != X0) && RegWriteM && (RdM == Rs2D) && !LoadM;

  assign rs1d_hit_e = (RdE != X0) && ((RdE == Rs1D) || (RdE == Rs2D));
  assign rs1d_hit_m = (RdM != X0) && ((RdM == Rs1D) || (RdM == Rs2D));

  assign lw_stall = LoadE && rs1d_hit_e;
  assign br_stall = BranchD && ((RegWriteE && rs1d_hit_e) || (LoadM && rs1d_hit_m));
  assign sb_stall = busy_rs1 || busy_rs2 || (LongD && busy_rd);

  // Occupancy seen by a long op leaving D next edge: current count, plus the
  // op dispatching now, minus a genuine retirement this cycle. The retirement
  // is moved to the limit side to keep the arithmetic unsigned.
  assign occupancy  = (PC_W+1)'(PendCnt) + (PC_W+1)'(LongIssueE);
  assign limit      = (PC_W+1)'(MAX_PEND) + (PC_W+1)'(clr_hit);
  assign full_stall = LongD && (occupancy >= limit);

  assign Stall  = lw_stall || br_stall || sb_stall || full_stall;
  assign StallF = Stall;
  assign StallD = Stall;
  assign FlushE = Stall;

  // Performance counter of stalled cycles, pinned at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      StallCycles <= '0;
    end else if (Stall && (StallCycles != {CNT_W{1'b1}})) begin
      StallCycles <= StallCycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_unit_sb.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit_sb
// Directed bench: a table of combinational vectors with hand-computed
// forwarding/stall results, then short multi-cycle scoreboard sequences.
// ---------------------------------------------------------------------------
module tb_hazard_unit_sb;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd;
  logic       BranchD, LongD, RegWriteE, LoadE, LoadM, LongIssueE;
  logic       RegWriteM, RegWriteW, LongDoneValid;
  logic [1:0] ForwardAE, ForwardBE;
  logic       ForwardAD, ForwardBD, StallF, StallD, FlushE, Stall, ErrSpurious;
  logic [2:0] PendCnt;
  logic [15:0] StallCycles;

  int passed;
  int total;

  hazard_unit_sb #(.RA_W(5), .MAX_PEND(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .BranchD(BranchD), .LongD(LongD),
    .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .RegWriteE(RegWriteE),
    .LoadE(LoadE), .LoadM(LoadM), .LongIssueE(LongIssueE),
    .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .LongDoneValid(LongDoneValid), .LongDoneRd(LongDoneRd),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE), .Stall(Stall),
    .PendCnt(PendCnt), .StallCycles(StallCycles), .ErrSpurious(ErrSpurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rs1d, rs2d, rdd;
    logic       branchd, longd;
    logic [4:0] rs1e, rs2e, rde;
    logic       regwritee, loade;
    logic [4:0] rdm;
    logic       regwritem, loadm;
    logic [4:0] rdw;
    logic       regwritew, donev;
    logic [4:0] doner;
    logic [1:0] fae, fbe;
    logic       fad, fbd, stall;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input int rs1d, input int rs2d, input int rdd,
                              input int br, input int lg,
                              input int rs1e, input int rs2e, input int rde,
                              input int rwe, input int lde,
                              input int rdm, input int rwm, input int ldm,
                              input int rdw, input int rww,
                              input int dv, input int dr,
                              input int fae, input int fbe,
                              input int fad, input int fbd, input int st);
    vec_t v;
    v.rs1d = 5'(rs1d); v.rs2d = 5'(rs2d); v.rdd = 5'(rdd);
    v.branchd = 1'(br); v.longd = 1'(lg);
    v.rs1e = 5'(rs1e); v.rs2e = 5'(rs2e); v.rde = 5'(rde);
    v.regwritee = 1'(rwe); v.loade = 1'(lde);
    v.rdm = 5'(rdm); v.regwritem = 1'(rwm); v.loadm = 1'(ldm);
    v.rdw = 5'(rdw); v.regwritew = 1'(rww);
    v.donev = 1'(dv); v.doner = 5'(dr);
    v.fae = 2'(fae); v.fbe = 2'(fbe);
    v.fad = 1'(fad); v.fbd = 1'(fbd); v.stall = 1'(st);
    return v;
  endfunction

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clearInputs();
    Rs1D = '0; Rs2D = '0; RdD = '0; BranchD = 1'b0; LongD = 1'b0;
    Rs1E = '0; Rs2E = '0; RdE = '0; RegWriteE = 1'b0; LoadE = 1'b0;
    LoadM = 1'b0; LongIssueE = 1'b0; RdM = '0; RdW = '0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; LongDoneValid = 1'b0; LongDoneRd = '0;
  endtask

  task automatic applyStimulus(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; RdD = v.rdd; BranchD = v.branchd; LongD = v.longd;
    Rs1E = v.rs1e; Rs2E = v.rs2e; RdE = v.rde; RegWriteE = v.regwritee; LoadE = v.loade;
    RdM = v.rdm; RegWriteM = v.regwritem; LoadM = v.loadm;
    RdW = v.rdw; RegWriteW = v.regwritew;
    LongDoneValid = v.donev; LongDoneRd = v.doner; LongIssueE = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clk);
    clearInputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1'b1;
    clearInputs();

    //            rs1d rs2d rdd br lg  rs1e rs2e rde rwe lde  rdm rwm ldm  rdw rww  dv dr  fae fbe fad fbd st
    vecs[0]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0,   0, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0, 0);
    vecs[1]  = mk(5, 1, 6, 0, 0,   0, 0, 5, 1, 1,   0, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0, 1);
    vecs[2]  = mk(0, 0, 0, 0, 0,   7, 3, 0, 0, 0,   7, 1, 0,   7, 1,   0, 0,   2, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0,   0, 7, 0, 0, 0,   7, 1, 0,   7, 1,   0, 0,   0, 2, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0,   4, 0, 0, 0, 0,   4, 0, 0,   4, 1,   0, 0,   1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0,   9, 9, 0, 0, 0,   9, 1, 0,   0, 0,   1, 9,   3, 3, 0, 0, 0);
    vecs[6]  = mk(3, 4, 0, 1, 0,   0, 0, 3, 1, 0,   0, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0, 1);
    vecs[7]  = mk(3, 4, 0, 1, 0,   0, 0, 0, 0, 0,   3, 1, 0,   0, 0,   0, 0,   0, 0, 1, 0, 0);
    vecs[8]  = mk(3, 4, 0, 1, 0,   0, 0, 0, 0, 0,   3, 1, 1,   0, 0,   0, 0,   0, 0, 0, 0, 1);
    vecs[9]  = mk(0, 4, 0, 0, 0,   0, 0, 0, 0, 0,   4, 1, 0,   0, 0,   0, 0,   0, 0, 0, 1, 0);
    vecs[10] = mk(3, 0, 0, 0, 0,   0, 0, 0, 0, 0,   3, 1, 1,   0, 0,   0, 0,   0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 1,   0, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0, 0);
    vecs[12] = mk(0, 0, 0, 1, 0,   0, 0, 0, 1, 0,   0, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0, 0);
    vecs[13] = mk(0, 5, 0, 0, 0,   0, 0, 5, 0, 1,   0, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0, 1);
    vecs[14] = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0,   0, 1, 0,   0, 0,   0, 0,   0, 0, 0, 0, 0);
    vecs[15] = mk(3, 4, 0, 1, 0,   0, 0, 4, 0, 0,   0, 0, 0,   0, 0,   0, 0,   0, 0, 0, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0,   0, 6, 0, 0, 0,   5, 1, 0,   6, 1,   0, 0,   0, 1, 0, 0, 0);

    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset PendCnt", int'(PendCnt), 0);
    checkOutput("reset StallCycles", int'(StallCycles), 0);
    checkOutput("reset ErrSpurious", int'(ErrSpurious), 0);
    checkOutput("reset Stall", int'(Stall), 0);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d ForwardAE", i), int'(ForwardAE), int'(vecs[i].fae));
      checkOutput($sformatf("vec%0d ForwardBE", i), int'(ForwardBE), int'(vecs[i].fbe));
      checkOutput($sformatf("vec%0d ForwardAD", i), int'(ForwardAD), int'(vecs[i].fad));
      checkOutput($sformatf("vec%0d ForwardBD", i), int'(ForwardBD), int'(vecs[i].fbd));
      checkOutput($sformatf("vec%0d Stall", i),     int'(Stall),     int'(vecs[i].stall));
      checkOutput($sformatf("vec%0d StallF", i),    int'(StallF),    int'(vecs[i].stall));
      checkOutput($sformatf("vec%0d StallD", i),    int'(StallD),    int'(vecs[i].stall));
      checkOutput($sformatf("vec%0d FlushE", i),    int'(FlushE),    int'(vecs[i].stall));
    end

    // div x9 dispatched while add x9 waits in D; released by the writeback.
    doReset();
    @(negedge clk);
    Rs1D = 5'd9; LongIssueE = 1'b1; RdE = 5'd9;
    #1 checkOutput("div issue bypass Stall", int'(Stall), 1);
    @(posedge clk); #1 checkOutput("div PendCnt after issue", int'(PendCnt), 1);
    @(negedge clk);
    LongIssueE = 1'b0; RdE = 5'd0;
    #1 checkOutput("div pending Stall", int'(Stall), 1);
    @(negedge clk);
    LongDoneValid = 1'b1; LongDoneRd = 5'd9; Rs1E = 5'd9;
    #1 checkOutput("div done Stall", int'(Stall), 0);
    checkOutput("div done ForwardAE", int'(ForwardAE), 3);
    @(posedge clk); #1 checkOutput("div PendCnt after done", int'(PendCnt), 0);
    checkOutput("div StallCycles", int'(StallCycles), 2);
    checkOutput("div ErrSpurious", int'(ErrSpurious), 0);

    // Fill the scoreboard with x1..x4, then probe the occupancy stall.
    doReset();
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      LongIssueE = 1'b1; RdE = 5'(r);
      @(posedge clk); #1 checkOutput($sformatf("fill PendCnt %0d", r), int'(PendCnt), r);
    end
    @(negedge clk);
    LongIssueE = 1'b0; RdE = 5'd0; LongD = 1'b1; RdD = 5'd10;
    #1 checkOutput("full Stall", int'(Stall), 1);
    @(negedge clk);
    LongDoneValid = 1'b1; LongDoneRd = 5'd2;
    #1 checkOutput("full with retire Stall", int'(Stall), 0);
    @(posedge clk); #1 checkOutput("retire PendCnt", int'(PendCnt), 3);
    @(negedge clk);
    LongDoneValid = 1'b0; LongDoneRd = 5'd0; RdD = 5'd3;
    #1 checkOutput("WAW Stall", int'(Stall), 1);
    @(negedge clk);
    RdD = 5'd10; LongIssueE = 1'b1; RdE = 5'd5;
    #1 checkOutput("full via issue Stall", int'(Stall), 1);
    @(posedge clk); #1 checkOutput("refill PendCnt", int'(PendCnt), 4);
    @(negedge clk);
    clearInputs();

    // Same-register set/clear, then reset mid-operation and a stale writeback.
    doReset();
    @(negedge clk);
    LongIssueE = 1'b1; RdE = 5'd8;
    @(posedge clk); #1 checkOutput("x8 PendCnt", int'(PendCnt), 1);
    @(negedge clk);
    LongDoneValid = 1'b1; LongDoneRd = 5'd8;
    @(posedge clk); #1 checkOutput("set+clr PendCnt", int'(PendCnt), 1);
    checkOutput("set+clr ErrSpurious", int'(ErrSpurious), 0);
    @(negedge clk);
    clearInputs();
    Rs1D = 5'd8;
    #1 checkOutput("set wins Stall", int'(Stall), 1);
    rst = 1'b1;
    #1 checkOutput("mid-op reset PendCnt", int'(PendCnt), 0);
    checkOutput("mid-op reset Stall", int'(Stall), 0);
    rst = 1'b0;
    @(negedge clk);
    Rs1D = 5'd0; LongDoneValid = 1'b1; LongDoneRd = 5'd8;
    @(posedge clk); #1 checkOutput("stale done ErrSpurious", int'(ErrSpurious), 1);
    checkOutput("stale done PendCnt", int'(PendCnt), 0);
    @(negedge clk);
    clearInputs();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
